mips_multi_ctrl: RTL

Main control unit for the multicycle MIPS core. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and register-enable in the shared-ALU, shared-memory datapath. It also contains the ALU decoder and the PC-enable logic, so the datapath needs no other control.

---
 rtl/mips_multi_ctrl_if.sv | 38 +++
 rtl/mips_multi_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mips_multi_ctrl_if.sv
// ============================================================================
// Module      : mips_multi_ctrl_if
// Description : Control bus between the multicycle MIPS controller and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_multi_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;

    // Controller side: consumes instruction fields and flags, drives controls.
    modport master (
        input  op, funct, zero,
        output memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen
    );

    modport slave (
        output op, funct, zero,
        input  memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen
    );
endinterface

`default_nettype wire

// File: rtl/mips_multi_ctrl.sv
// ============================================================================
// Module      : mips_multi_ctrl
// Description : Multicycle MIPS main control FSM, ALU decoder and PC enable.
//               Define MIPS_BNE_EN to add the bne execute state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multi_ctrl (
    input  wire                       clk,
    input  wire                       reset,
    mips_multi_ctrl_if.master         bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MIPS_BNE_EN
        , BNEEX = 4'd12
`endif
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef MIPS_BNE_EN
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;
`ifdef MIPS_BNE_EN
    logic       w_branchne;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE: begin
                case (bus.op)
                    c_OP_LW, c_OP_SW: w_next = MEMADR;
                    c_OP_RTYPE:       w_next = RTYPEEX;
                    c_OP_BEQ:         w_next = BEQEX;
                    c_OP_ADDI:        w_next = ADDIEX;
                    c_OP_J:           w_next = JEX;
`ifdef MIPS_BNE_EN
                    c_OP_BNE:         w_next = BNEEX;
`endif
                    default:          w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (bus.op == c_OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = MEMWB;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // Moore decode: every control except pcen depends on state alone.
    always_comb begin
        bus.memwrite = 1'b0;
        bus.iord     = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        w_aluop      = 2'b00;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
`ifdef MIPS_BNE_EN
        w_branchne   = 1'b0;
`endif
        case (r_state)
            FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = 1'b1;
                w_pcwrite   = 1'b1;
            end
            DECODE:  bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD:   bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                w_aluop     = 2'b10;
            end
            RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BEQEX: begin
                bus.alusrca = 1'b1;
                w_aluop     = 2'b01;
                bus.pcsrc   = 2'b01;
                w_branch    = 1'b1;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ADDIWB:  bus.regwrite = 1'b1;
            JEX: begin
                bus.pcsrc = 2'b10;
                w_pcwrite = 1'b1;
            end
`ifdef MIPS_BNE_EN
            BNEEX: begin
                bus.alusrca = 1'b1;
                w_aluop     = 2'b01;
                bus.pcsrc   = 2'b01;
                w_branchne  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        bus.alucontrol = 3'b010;
        case (w_aluop)
            2'b01:   bus.alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end

`ifdef MIPS_BNE_EN
    assign bus.pcen = w_pcwrite | (w_branch & bus.zero) | (w_branchne & ~bus.zero);
`else
    assign bus.pcen = w_pcwrite | (w_branch & bus.zero);
`endif

endmodule

`default_nettype wire
